e1_hdb3_tx: RTL
===============

// Module: e1_hdb3_tx
// PURPOSE
//  E1 line transmitter, the transmit-side counterpart of the HDB3 receiver on rxp/rxn.
//  - Serialises bytes MSB-first, HDB3-encodes them and drives 50%-duty RZ pulses on txp/txn.
//  - Runs on the 16.384 MHz host clock (8x the 2.048 Mbit/s line rate).
//  - Fed by the AXI-slave register logic in mkTop through a valid/ready byte port.
// PARAMETERS
//  TICKS_PER_BIT  8   clk cycles per line bit (>=2)
//  PULSE_TICKS    4   cycles txp/txn held high within a bit period (1..TICKS_PER_BIT)
//  IDLE_BIT       1   bit value sent on underrun (1 = AIS all-ones)
// PORTS
//  clk           in   1  host clock, single clock domain
//  reset         in   1  synchronous, active-high
//  in_valid      in   1  byte offered
//  in_ready      out  1  byte accepted when in_valid & in_ready
//  in_data       in   8  payload byte, bit 7 sent first
//  txp           out  1  positive-pulse line drive
//  txn           out  1  negative-pulse line drive (never high with txp)
//  underrun      out  1  one-cycle pulse per bit period that carried IDLE_BIT
//  underrun_cnt  out  32 only with E1_TX_UNDERRUN_CNT_EN
// BEHAVIOUR
//  Reset values (next edge after reset=1)
//  - txp=0, txn=0, underrun=0, in_ready=1, underrun_cnt=0.
//  - tick=0, window=4xZERO, parity=0, last_pol=NEG (first mark goes positive).
//  - Byte buffer and shifter are emptied; a pending byte is discarded, even mid-byte.
//  Timing
//  - tick counts 0..TICKS_PER_BIT-1 and wraps. The boundary is tick==TICKS_PER_BIT-1.
//  Input path
//  - One-deep byte buffer. in_ready = !buf_full, registered; no comb path from in_valid.
//  - At a boundary with the shifter empty and buf_full, the byte moves to the shifter.
//  - buf_full clears on that edge, so in_ready rises the next cycle.
//  - Accept and drain in the same cycle is impossible: ready was low.
//  - At a boundary with shifter and buffer both empty, IDLE_BIT is used and underrun=1 for that cycle.
//  HDB3 window: 4-symbol shift register with symbols {ZERO, MARK, B, V}, advanced at each boundary
//  - New bit enters as MARK (1) or ZERO (0). parity toggles on each MARK entering.
//  - If the new symbol and the three previous window entries are all ZERO:
//    - parity odd  -> 000V: newest slot becomes V.
//    - parity even -> B00V: oldest slot becomes B, newest becomes V.
//    - In both cases parity is cleared.
//  - V is never treated as ZERO in later checks.
//  Output mapping: the symbol leaving the window is latched for the next bit period
//  - MARK or B -> pol = ~last_pol; last_pol <= pol.
//  - V -> pol = last_pol; last_pol unchanged.
//  - ZERO -> no pulse.
//  Pulse shaping
//  - pol POS drives txp=1, NEG drives txn=1, for cycles tick 0..PULSE_TICKS-1 of the bit period; 0 otherwise.
//  - Latency: a bit enters the window at boundary k. Its pulse starts the cycle after boundary k+4.
//  Invariants
//  - Never more than 3 consecutive zero bit periods.
//  - Consecutive V pulses alternate polarity.
//  - txp & txn never both 1.
// CONFIGURATION
//  E1_TX_UNDERRUN_CNT_EN
//  - Defined: underrun_cnt increments on each underrun pulse, saturating at 32'hFFFFFFFF, cleared by reset.
//  - Undefined: port absent; no counter logic.
// TESTING
//  1. Reset, then 0xFF,0xFF streamed -> after 4-bit latency pulses alternate +,-,+,- ... (first +);
//     txp high exactly 4 of 8 cycles.
//  2. After reset send 0x80,0x00 -> symbols +,0,0,0,+V,-B,0,0,-V; parity cleared after each substitution.
//  3. Hold in_valid=0 after reset -> all-ones AIS (alternating marks); underrun pulses once per 8 cycles;
//     underrun_cnt=N after N bit periods (macro on).
//  4. Backpressure: in_valid held high with 0xA5,0x3C queued -> in_ready low until the first byte reaches
//     the shifter; no byte lost or duplicated; line decodes to A5 3C.
//  5. Assert reset for 1 cycle at tick 2 of a pulse -> txp=txn=0 next cycle; next mark is positive;
//     in_ready=1.
//  6. Random 4096-byte stream through a reference HDB3 model -> bit-exact line; no 4-zero runs;
//     txp&txn never 1.

Source files
------------

// File: rtl/e1_hdb3_tx.sv
// ---------------------------------------------------------------------------
// e1_hdb3_tx -- E1 line transmitter (HDB3, RZ pulses)
//
// Takes bytes from a valid/ready port and sends them MSB first at one bit per
// TICKS_PER_BIT clocks. Each bit goes through a 4-symbol HDB3 window, and each
// symbol leaving the window becomes a return-to-zero pulse on txp or txn.
// If no byte is available at a bit boundary, IDLE_BIT is sent (AIS when 1)
// and underrun pulses for one cycle.
//
// Ports
//   clk           host clock (16.384 MHz, 8x line rate with defaults)
//   reset         synchronous, active-high
//   in_valid      byte offered
//   in_ready      byte accepted when in_valid & in_ready (registered, = !buf_full)
//   in_data[7:0]  payload byte, bit 7 sent first
//   txp / txn     positive / negative pulse line drive, never both high
//   underrun      one-cycle pulse per bit period that carried IDLE_BIT
//   underrun_cnt  saturating count of underrun pulses (only when the
//                 E1_TX_UNDERRUN_CNT_EN macro is defined)
//
// Optional feature macro: E1_TX_UNDERRUN_CNT_EN
// ---------------------------------------------------------------------------
module e1_hdb3_tx #(
    parameter int TICKS_PER_BIT = 8,
    parameter int PULSE_TICKS   = 4,
    parameter bit IDLE_BIT      = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    output logic        txp,
    output logic        txn,
    output logic        underrun
`ifdef E1_TX_UNDERRUN_CNT_EN
    ,
    output logic [31:0] underrun_cnt
`endif
);

    localparam int TW = $clog2(TICKS_PER_BIT);
    localparam logic [TW-1:0] LAST_TICK = TW'(TICKS_PER_BIT - 1);

    typedef enum logic [1:0] {SYM_ZERO, SYM_MARK, SYM_B, SYM_V} sym_t;
    typedef enum logic {POL_NEG, POL_POS} pol_t;

    // Bit timing
    logic [TW-1:0] tick;
    logic [TW-1:0] tick_nx;
    logic          boundary;

    // Input path: one-deep buffer feeding the shifter
    logic          buf_full;
    logic [7:0]    buf_data;
    logic [6:0]    sh_data;
    logic [6:0]    sh_data_nx;
    logic [2:0]    sh_cnt;      // bits still waiting in the shifter
    logic [2:0]    sh_cnt_nx;
    logic          take_buf;
    logic          idle;
    logic          bit_val;
    logic          accept;

    // HDB3 window: index 0 is the oldest symbol, index 3 the newest
    sym_t          win    [4];
    sym_t          win_nx [4];
    sym_t          leaving;
    logic          parity;
    logic          parity_nx;

    // Line polarity and pulse of the current bit period
    pol_t          last_pol;
    pol_t          last_pol_nx;
    pol_t          cur_pol;
    pol_t          pol_nx;
    logic          cur_pulse;
    logic          pulse_nx;
    logic          act_pulse;
    pol_t          act_pol;
    logic          shape_on;

    assign boundary = (tick == LAST_TICK);
    assign tick_nx  = boundary ? '0 : tick + 1'b1;
    assign in_ready = !buf_full;
    assign accept   = in_valid && !buf_full;

    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        bit_val     = IDLE_BIT;
        take_buf    = 1'b0;
        idle        = 1'b0;
        sh_data_nx  = sh_data;
        sh_cnt_nx   = sh_cnt;
        parity_nx   = parity;
        win_nx[0]   = win[1];
        win_nx[1]   = win[2];
        win_nx[2]   = win[3];
        win_nx[3]   = SYM_ZERO;
        leaving     = win[0];
        pol_nx      = last_pol;
        last_pol_nx = last_pol;
        pulse_nx    = 1'b0;

        // Bit source: shifter first, then the buffer (its MSB goes out on the
        // same boundary it is loaded), otherwise the idle bit.
        if (sh_cnt != 3'd0) begin
            bit_val    = sh_data[6];
            sh_data_nx = {sh_data[5:0], 1'b0};
            sh_cnt_nx  = sh_cnt - 3'd1;
        end else if (buf_full) begin
            bit_val    = buf_data[7];
            sh_data_nx = buf_data[6:0];
            sh_cnt_nx  = 3'd7;
            take_buf   = 1'b1;
        end else begin
            idle = 1'b1;
        end

        if (bit_val) begin
            win_nx[3] = SYM_MARK;
            parity_nx = !parity;
        end else if (win[1] == SYM_ZERO && win[2] == SYM_ZERO && win[3] == SYM_ZERO) begin
            // Fourth zero in a row: 000V if an odd number of marks went out
            // since the last violation, B00V otherwise, so that successive
            // violations alternate polarity.
            if (!parity) begin
                win_nx[0] = SYM_B;
            end
            win_nx[3] = SYM_V;
            parity_nx = 1'b0;
        end

        case (leaving)
            SYM_MARK, SYM_B: begin
                pol_nx      = (last_pol == POL_POS) ? POL_NEG : POL_POS;
                last_pol_nx = pol_nx;
                pulse_nx    = 1'b1;
            end
            SYM_V: begin
                pulse_nx = 1'b1;   // violation repeats the previous polarity
            end
            default: begin
                pulse_nx = 1'b0;
            end
        endcase
    end

    // The symbol latched at a boundary drives the bit period that starts on
    // the following cycle; the pulse occupies ticks 0..PULSE_TICKS-1.
    assign act_pulse = boundary ? pulse_nx : cur_pulse;
    assign act_pol   = boundary ? pol_nx   : cur_pol;
    assign shape_on  = (int'(tick_nx) < PULSE_TICKS);

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            tick      <= '0;
            buf_full  <= 1'b0;
            buf_data  <= '0;
            sh_data   <= '0;
            sh_cnt    <= '0;
            for (int i = 0; i < 4; i++) begin
                win[i] <= SYM_ZERO;
            end
            parity    <= 1'b0;
            last_pol  <= POL_NEG;
            cur_pol   <= POL_NEG;
            cur_pulse <= 1'b0;
            txp       <= 1'b0;
            txn       <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            tick     <= tick_nx;
            underrun <= boundary && idle;
            txp      <= act_pulse && (act_pol == POL_POS) && shape_on;
            txn      <= act_pulse && (act_pol == POL_NEG) && shape_on;

            // accept needs buf_full=0 and take_buf needs buf_full=1, so the
            // two never collide.
            if (accept) begin
                buf_full <= 1'b1;
                buf_data <= in_data;
            end

            if (boundary) begin
                if (take_buf) begin
                    buf_full <= 1'b0;
                end
                sh_data   <= sh_data_nx;
                sh_cnt    <= sh_cnt_nx;
                for (int i = 0; i < 4; i++) begin
                    win[i] <= win_nx[i];
                end
                parity    <= parity_nx;
                last_pol  <= last_pol_nx;
                cur_pol   <= pol_nx;
                cur_pulse <= pulse_nx;
            end
        end
    end

`ifdef E1_TX_UNDERRUN_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            underrun_cnt <= '0;
        end else if (boundary && idle && underrun_cnt != 32'hFFFF_FFFF) begin
            underrun_cnt <= underrun_cnt + 32'd1;
        end
    end
`endif

endmodule
